// File: rtl/mopshub_init_supervisor_if.sv
// Status/control bundle between the MOPS-Hub start-up supervisor and the
// datapath/monitor that consumes its strobes.
interface mopshub_init_supervisor_if;
    logic [4:0] n_buses;
    logic       osc_auto_trim_mopshub;
    logic       endwait_all;
    logic       start_init;
    logic       rst_bus;
    logic       power_bus_en;
    logic [4:0] power_bus_cnt;
    logic       start_trim_ack;
    logic       ext_counter_gen;
    logic       end_trim_bus;
    logic       end_power_init;
    logic       end_init;
    logic       sign_on_sig;
    logic       hub_ready;

    // Supervisor side: consumes configuration/release, drives status strobes.
    modport master (
        input  n_buses, osc_auto_trim_mopshub, endwait_all,
        output start_init, rst_bus, power_bus_en, power_bus_cnt,
               start_trim_ack, ext_counter_gen, end_trim_bus,
               end_power_init, end_init, sign_on_sig, hub_ready
    );

    // Datapath/monitor side.
    modport slave (
        output n_buses, osc_auto_trim_mopshub, endwait_all,
        input  start_init, rst_bus, power_bus_en, power_bus_cnt,
               start_trim_ack, ext_counter_gen, end_trim_bus,
               end_power_init, end_init, sign_on_sig, hub_ready
    );
endinterface

// File: rtl/mopshub_init_supervisor.sv
// MOPS-Hub start-up supervisor: bus reset pulse, sequential per-bus power-up
// with optional oscillator-trim window, end-of-init/sign-on strobes, then a
// wait for host release (or timeout) before declaring the hub ready.
// All outputs are registered as a decode of the next state.
module mopshub_init_supervisor #(
    parameter int RST_CYCLES   = 8,
    parameter int POWER_WAIT   = 16,
    parameter int TRIM_CYCLES  = 64,
    parameter int WAIT_TIMEOUT = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    mopshub_init_supervisor_if.master   bus
);

    localparam int MAX_AB  = (RST_CYCLES > POWER_WAIT) ? RST_CYCLES : POWER_WAIT;
    localparam int MAX_CD  = (TRIM_CYCLES > WAIT_TIMEOUT) ? TRIM_CYCLES : WAIT_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] POWER_LAST = CNT_W'(POWER_WAIT - 1);
    localparam logic [CNT_W-1:0] TRIM_LAST  = CNT_W'(TRIM_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TIMEOUT - 1);
    localparam logic [4:0]       BUS_MAX    = 5'd15;

    typedef enum logic [3:0] {
        IDLE, RESET_BUS, POWER_ON, TRIM_START, TRIM, TRIM_END,
        NEXT_BUS, INIT_DONE, SIGN_ON, WAIT_ALL, RUN
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       bus_cnt_q, bus_cnt_d;
    logic [4:0]       n_clamped;

    logic start_init_q, start_init_d;
    logic rst_bus_q, rst_bus_d;
    logic power_bus_en_q, power_bus_en_d;
    logic start_trim_ack_q, start_trim_ack_d;
    logic ext_counter_gen_q, ext_counter_gen_d;
    logic end_trim_bus_q, end_trim_bus_d;
    logic end_power_init_q, end_power_init_d;
    logic end_init_q, end_init_d;
    logic sign_on_sig_q, sign_on_sig_d;
    logic hub_ready_q, hub_ready_d;

    assign n_clamped = (bus.n_buses > BUS_MAX) ? BUS_MAX : bus.n_buses;

    // Next-state, counters and registered-output decode of the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_cnt_d = bus_cnt_q;

        case (state_q)
            IDLE: begin
                state_d   = RESET_BUS;
                cnt_d     = CNT_ZERO;
                bus_cnt_d = 5'd0;
            end
            RESET_BUS: begin
                if (cnt_q == RST_LAST) begin
                    state_d   = POWER_ON;
                    cnt_d     = CNT_ZERO;
                    bus_cnt_d = 5'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            POWER_ON: begin
                if (cnt_q == POWER_LAST) begin
                    state_d = bus.osc_auto_trim_mopshub ? TRIM_START : NEXT_BUS;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TRIM_START: begin
                state_d = TRIM;
                cnt_d   = CNT_ZERO;
            end
            TRIM: begin
                if (cnt_q == TRIM_LAST) begin
                    state_d = TRIM_END;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            TRIM_END: begin
                state_d = NEXT_BUS;
            end
            NEXT_BUS: begin
                // The termination decision was already taken on entry and is
                // held in end_power_init_q, so strobe and exit always agree.
                if (end_power_init_q) begin
                    state_d = INIT_DONE;
                end else begin
                    state_d   = POWER_ON;
                    cnt_d     = CNT_ZERO;
                    bus_cnt_d = bus_cnt_q + 5'd1;
                end
            end
            INIT_DONE: begin
                state_d = SIGN_ON;
            end
            SIGN_ON: begin
                state_d = WAIT_ALL;
                cnt_d   = CNT_ZERO;
            end
            WAIT_ALL: begin
                if (bus.endwait_all || (cnt_q == WAIT_LAST)) begin
                    state_d = RUN;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase

        start_init_d      = (state_q == IDLE);
        rst_bus_d         = (state_d == RESET_BUS);
        power_bus_en_d    = (state_d == POWER_ON) || (state_d == TRIM_START) ||
                            (state_d == TRIM) || (state_d == TRIM_END);
        start_trim_ack_d  = (state_d == TRIM_START);
        ext_counter_gen_d = (state_d == TRIM);
        end_trim_bus_d    = (state_d == TRIM_END);
        end_power_init_d  = (state_d == NEXT_BUS) && (bus_cnt_d == n_clamped);
        end_init_d        = (state_d == INIT_DONE);
        sign_on_sig_d     = (state_d == SIGN_ON);
        hub_ready_d       = (state_d == RUN);
    end

    // State, counters and output registers; async active-low reset to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= IDLE;
            cnt_q             <= CNT_ZERO;
            bus_cnt_q         <= 5'd0;
            start_init_q      <= 1'b0;
            rst_bus_q         <= 1'b0;
            power_bus_en_q    <= 1'b0;
            start_trim_ack_q  <= 1'b0;
            ext_counter_gen_q <= 1'b0;
            end_trim_bus_q    <= 1'b0;
            end_power_init_q  <= 1'b0;
            end_init_q        <= 1'b0;
            sign_on_sig_q     <= 1'b0;
            hub_ready_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            bus_cnt_q         <= bus_cnt_d;
            start_init_q      <= start_init_d;
            rst_bus_q         <= rst_bus_d;
            power_bus_en_q    <= power_bus_en_d;
            start_trim_ack_q  <= start_trim_ack_d;
            ext_counter_gen_q <= ext_counter_gen_d;
            end_trim_bus_q    <= end_trim_bus_d;
            end_power_init_q  <= end_power_init_d;
            end_init_q        <= end_init_d;
            sign_on_sig_q     <= sign_on_sig_d;
            hub_ready_q       <= hub_ready_d;
        end
    end

    assign bus.start_init      = start_init_q;
    assign bus.rst_bus         = rst_bus_q;
    assign bus.power_bus_en    = power_bus_en_q;
    assign bus.power_bus_cnt   = bus_cnt_q;
    assign bus.start_trim_ack  = start_trim_ack_q;
    assign bus.ext_counter_gen = ext_counter_gen_q;
    assign bus.end_trim_bus    = end_trim_bus_q;
    assign bus.end_power_init  = end_power_init_q;
    assign bus.end_init        = end_init_q;
    assign bus.sign_on_sig     = sign_on_sig_q;
    assign bus.hub_ready       = hub_ready_q;

endmodule

// File: tb/tb_mopshub_init_supervisor.sv
// Directed self-checking bench for the MOPS-Hub start-up supervisor.
module tb_mopshub_init_supervisor;

    logic clk;
    logic rst;
    mopshub_init_supervisor_if bus ();

    mopshub_init_supervisor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 40 MHz nominal clock.
    initial clk = 1'b0;
    always #12.5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int siCount, stCount, etCount, extCount, epiCount;
    int siCycle, epiCycle, epiBus, lastStart, gapErr;
    int maxCnt, prevCnt, stepErr, overlapErr, hubRise;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Drive the configuration and host-release inputs.
    task automatic applyStimulus(input logic [4:0] n, input logic trim, input logic endwait);
        bus.n_buses               = n;
        bus.osc_auto_trim_mopshub = trim;
        bus.endwait_all           = endwait;
    endtask

    // Packed snapshot: {power_bus_cnt, start_init, rst_bus, power_bus_en,
    // start_trim_ack, ext_counter_gen, end_trim_bus, end_power_init,
    // end_init, sign_on_sig, hub_ready}.
    function automatic logic [31:0] getVec();
        return {17'd0, bus.power_bus_cnt, bus.start_init, bus.rst_bus, bus.power_bus_en,
                bus.start_trim_ack, bus.ext_counter_gen, bus.end_trim_bus,
                bus.end_power_init, bus.end_init, bus.sign_on_sig, bus.hub_ready};
    endfunction

    // Expected snapshot for the default scenario at cycle k.
    function automatic logic [31:0] expVec1(input int k);
        logic [31:0] v;
        v = 32'd0;
        if (k == 1)             v[9] = 1'b1;
        if (k >= 1 && k <= 8)   v[8] = 1'b1;
        if (k >= 9 && k <= 24)  v[7] = 1'b1;
        if (k == 25)            v[3] = 1'b1;
        if (k == 26)            v[2] = 1'b1;
        if (k == 27)            v[1] = 1'b1;
        if (k >= 41)            v[0] = 1'b1;
        return v;
    endfunction

    task automatic clearStats();
        siCount = 0; stCount = 0; etCount = 0; extCount = 0; epiCount = 0;
        siCycle = -1; epiCycle = -1; epiBus = -1; lastStart = -1000; gapErr = 0;
        maxCnt = 0; prevCnt = 0; stepErr = 0; overlapErr = 0; hubRise = -1;
    endtask

    // Advance one clock and record strobe statistics at the falling edge.
    task automatic stepCycle();
        int strobes;
        int c;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        c = int'(bus.power_bus_cnt);
        strobes = int'(bus.start_init) + int'(bus.start_trim_ack) + int'(bus.end_trim_bus) +
                  int'(bus.end_power_init) + int'(bus.end_init) + int'(bus.sign_on_sig);
        if (strobes > 1) overlapErr++;
        if (bus.start_init) begin siCount++; siCycle = cyc; end
        if (bus.start_trim_ack) begin stCount++; lastStart = cyc; end
        if (bus.end_trim_bus) begin
            etCount++;
            if (cyc - lastStart != 65) gapErr++;
        end
        if (bus.ext_counter_gen) extCount++;
        if (bus.end_power_init) begin epiCount++; epiCycle = cyc; epiBus = c; end
        if (bus.hub_ready && hubRise < 0) hubRise = cyc;
        if (c > maxCnt) maxCnt = c;
        if (c != prevCnt && c != prevCnt + 1 && c != 0) stepErr++;
        prevCnt = c;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    // Hold reset a few cycles, verify the reset state, release at a falling edge.
    task automatic resetDut(input string tag);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput({tag, "_reset_state"}, getVec(), 32'd0);
        rst = 1'b1;
        cyc = 0;
        clearStats();
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(5'd0, 1'b0, 1'b0);
        clearStats();

        // Defaults, single bus, no trim; release pulsed in POWER_ON and at 40.
        $display("[TB] scenario: defaults n_buses=0 no trim");
        resetDut("t1");
        for (int k = 1; k <= 50; k++) begin
            stepCycle();
            checkOutput($sformatf("t1_cycle%0d", k), getVec(), expVec1(k));
            bus.endwait_all = (k == 12) || (k == 40);
        end
        bus.endwait_all = 1'b0;
        checkOutput("t1_no_trim_ack", 32'(stCount), 32'd0);

        // 16 buses with trim throughout, release never given: timeout path.
        $display("[TB] scenario: n_buses=15 trim on, timeout");
        applyStimulus(5'd15, 1'b1, 1'b0);
        resetDut("t2");
        runCycles(5440);
        checkOutput("t2_start_init_count", 32'(siCount), 32'd1);
        checkOutput("t2_trim_ack_count", 32'(stCount), 32'd16);
        checkOutput("t2_end_trim_count", 32'(etCount), 32'd16);
        checkOutput("t2_trim_gap_errors", 32'(gapErr), 32'd0);
        checkOutput("t2_ext_counter_cycles", 32'(extCount), 32'd1024);
        checkOutput("t2_end_power_init_count", 32'(epiCount), 32'd1);
        checkOutput("t2_end_power_init_cycle", 32'(epiCycle), 32'd1336);
        checkOutput("t2_end_power_init_bus", 32'(epiBus), 32'd15);
        checkOutput("t2_max_bus_cnt", 32'(maxCnt), 32'd15);
        checkOutput("t2_bus_cnt_step_errors", 32'(stepErr), 32'd0);
        checkOutput("t2_strobe_overlap", 32'(overlapErr), 32'd0);
        checkOutput("t2_hub_ready_rise", 32'(hubRise), 32'd5435);
        checkOutput("t2_bus_cnt_held_in_run", 32'(bus.power_bus_cnt), 32'd15);

        // n_buses above range is clamped to 15.
        $display("[TB] scenario: n_buses=20 clamp");
        applyStimulus(5'd20, 1'b0, 1'b0);
        resetDut("t3");
        runCycles(300);
        checkOutput("t3_max_bus_cnt", 32'(maxCnt), 32'd15);
        checkOutput("t3_end_power_init_count", 32'(epiCount), 32'd1);
        checkOutput("t3_end_power_init_cycle", 32'(epiCycle), 32'd280);
        checkOutput("t3_end_power_init_bus", 32'(epiBus), 32'd15);
        checkOutput("t3_no_trim_ack", 32'(stCount), 32'd0);

        // Trim dropped mid-window on bus 0: window completes, bus 1 skips trim.
        $display("[TB] scenario: trim dropped during bus 0 window");
        applyStimulus(5'd1, 1'b1, 1'b0);
        resetDut("t4");
        runCycles(50);
        bus.osc_auto_trim_mopshub = 1'b0;
        runCycles(70);
        checkOutput("t4_trim_ack_count", 32'(stCount), 32'd1);
        checkOutput("t4_ext_counter_cycles", 32'(extCount), 32'd64);
        checkOutput("t4_end_trim_count", 32'(etCount), 32'd1);
        checkOutput("t4_trim_gap_errors", 32'(gapErr), 32'd0);
        checkOutput("t4_end_power_init_cycle", 32'(epiCycle), 32'd108);
        checkOutput("t4_end_power_init_bus", 32'(epiBus), 32'd1);

        // Reset asserted during bus 5 trim window, then restart from bus 0.
        $display("[TB] scenario: reset during bus 5 trim");
        applyStimulus(5'd15, 1'b1, 1'b0);
        resetDut("t5");
        runCycles(470);
        checkOutput("t5_bus_before_reset", 32'(bus.power_bus_cnt), 32'd5);
        checkOutput("t5_trim_before_reset", 32'(bus.ext_counter_gen), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("t5_async_clear", getVec(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        clearStats();
        runCycles(1);
        checkOutput("t5_restart_cycle1", getVec(), 32'h300);
        runCycles(8);
        checkOutput("t5_restart_cycle9", getVec(), 32'h080);
        checkOutput("t5_start_init_cycle", 32'(siCycle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
